// File: rtl/mem_col_ccl_stream_bank_if.sv
// Command and read-stream bundle between the CCL bank array and the PE columns.
// The master side is the PE column array; the slave side is the bank array.
interface mem_col_ccl_stream_bank_if #(
    parameter int N_PE_COL = 5,
    parameter int AW       = 12,
    parameter int LEN_W    = 13,
    parameter int DATA_W   = 5
);
    logic [N_PE_COL-1:0]             cmd_vld;
    logic [N_PE_COL-1:0]             cmd_rdy;
    logic [N_PE_COL-1:0][AW-1:0]     cmd_addr;
    logic [N_PE_COL-1:0][LEN_W-1:0]  cmd_len;
    logic [N_PE_COL-1:0][DATA_W-1:0] rd_data;
    logic [N_PE_COL-1:0]             rd_vld;
    logic [N_PE_COL-1:0]             rd_rdy;
    logic [N_PE_COL-1:0]             rd_last;
    logic [N_PE_COL-1:0]             done;
    logic [N_PE_COL-1:0]             par_err;

    modport master (
        output cmd_vld, cmd_addr, cmd_len, rd_rdy,
        input  cmd_rdy, rd_data, rd_vld, rd_last, done, par_err
    );

    modport slave (
        input  cmd_vld, cmd_addr, cmd_len, rd_rdy,
        output cmd_rdy, rd_data, rd_vld, rd_last, done, par_err
    );
endinterface

// File: rtl/mem_col_ccl_stream_bank.sv
// Per-column CCL memory banks with command-driven burst read streams and a 2-entry skid buffer.
// Optional stored even parity per word is enabled with `define CCL_PARITY_EN.
module mem_col_ccl_stream_bank #(
    parameter int N_PE_COL   = 5,
    parameter int DEPTH      = 4096,
    parameter int DATA_W     = 5,
    parameter int LEN_W      = 13,
    parameter int SPI_ADDR_W = 12,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_col_ccl_stream_bank_if.slave bus,
    input  logic [N_PE_COL-1:0]      spi_wen,
    input  logic [SPI_ADDR_W-1:0]    SPI_ADDR,
    input  logic [31:0]              SPI_DATA
);

`ifdef CCL_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [MW-1:0]     wr_word;
    logic              unused_spi;

    assign wr_addr    = SPI_ADDR[AW-1:0];
    assign wr_data    = SPI_DATA[DATA_W-1:0];
    assign unused_spi = ^{SPI_ADDR, SPI_DATA};

`ifdef CCL_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    logic [N_PE_COL-1:0]             cmd_rdy_v;
    logic [N_PE_COL-1:0]             rd_vld_v;
    logic [N_PE_COL-1:0]             rd_last_v;
    logic [N_PE_COL-1:0]             done_v;
    logic [N_PE_COL-1:0]             par_err_v;
    logic [N_PE_COL-1:0][DATA_W-1:0] rd_data_v;

    for (genvar i = 0; i < N_PE_COL; i++) begin : g_ch
        logic [MW-1:0]     mem [DEPTH];
        state_t            state;
        logic [AW-1:0]     raddr;
        logic [LEN_W-1:0]  remain;
        logic              cmd_rdy_q;
        logic              done_q;
        logic              par_err_q;

        // Skid buffer: slot 0 is always the head presented on the stream.
        logic              v0, v1, l0, l1;
        logic [DATA_W-1:0] d0, d1;
        logic              nv0, nv1, nl0, nl1;
        logic [DATA_W-1:0] nd0, nd1;

        logic [MW-1:0]     rd_word;
        logic              issue;
        logic              pop;
        logic              issue_last;

        // NOTE: memory has no reset; contents survive rst_n and are loaded over SPI.
        always_ff @(posedge clk) begin
            if (spi_wen[i]) begin
                mem[wr_addr] <= wr_word;
            end
        end

        // Slot 1 empty means occupancy < 2; the read lands in the skid at the issue edge.
        assign rd_word    = mem[raddr];
        assign pop        = v0 && bus.rd_rdy[i];
        assign issue      = (state == S_RUN) && !v1 && !spi_wen[i];
        assign issue_last = (remain == LEN_W'(1));

        // NOTE: combinational next-state uses blocking assignments; registers use non-blocking.
        always_comb begin
            // NOTE: every output gets a default first so no latch is inferred.
            nv0 = v0;
            nv1 = v1;
            nl0 = l0;
            nl1 = l1;
            nd0 = d0;
            nd1 = d1;
            if (pop) begin
                nv0 = v1;
                nl0 = l1;
                nd0 = d1;
                nv1 = 1'b0;
            end
            if (issue) begin
                if (!nv0) begin
                    nv0 = 1'b1;
                    nl0 = issue_last;
                    nd0 = rd_word[DATA_W-1:0];
                end else begin
                    nv1 = 1'b1;
                    nl1 = issue_last;
                    nd1 = rd_word[DATA_W-1:0];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= S_IDLE;
                raddr     <= '0;
                remain    <= '0;
                cmd_rdy_q <= 1'b1;
                done_q    <= 1'b0;
                par_err_q <= 1'b0;
                v0        <= 1'b0;
                v1        <= 1'b0;
                l0        <= 1'b0;
                l1        <= 1'b0;
                d0        <= '0;
                d1        <= '0;
            end else begin
                done_q <= 1'b0;
                v0     <= nv0;
                v1     <= nv1;
                l0     <= nl0;
                l1     <= nl1;
                d0     <= nd0;
                d1     <= nd1;
                case (state)
                    S_IDLE: begin
                        if (bus.cmd_vld[i]) begin
                            par_err_q <= 1'b0;
                            if (bus.cmd_len[i] != '0) begin
                                raddr     <= bus.cmd_addr[i];
                                remain    <= bus.cmd_len[i];
                                state     <= S_RUN;
                                cmd_rdy_q <= 1'b0;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (issue) begin
                            raddr  <= raddr + AW'(1);
                            remain <= remain - LEN_W'(1);
                            if (issue_last) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // Done once the final beat leaves the buffer.
                        if (!v0 || (pop && !v1)) begin
                            done_q    <= 1'b1;
                            cmd_rdy_q <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        cmd_rdy_q <= 1'b1;
                    end
                endcase
`ifdef CCL_PARITY_EN
                if (issue && (^rd_word)) begin
                    par_err_q <= 1'b1;
                end
`endif
            end
        end

        assign cmd_rdy_v[i] = cmd_rdy_q;
        assign rd_vld_v[i]  = v0;
        assign rd_last_v[i] = l0;
        assign rd_data_v[i] = d0;
        assign done_v[i]    = done_q;
`ifdef CCL_PARITY_EN
        assign par_err_v[i] = par_err_q;
`else
        assign par_err_v[i] = 1'b0;
`endif
    end

    assign bus.cmd_rdy = cmd_rdy_v;
    assign bus.rd_vld  = rd_vld_v;
    assign bus.rd_last = rd_last_v;
    assign bus.rd_data = rd_data_v;
    assign bus.done    = done_v;
    assign bus.par_err = par_err_v;

endmodule

// File: tb/tb_mem_col_ccl_stream_bank.sv
// Scoreboard bench for mem_col_ccl_stream_bank: expected beats are queued when a command is
// issued and compared as the stream hands them over. Define CCL_PARITY_EN to cover parity.
module tb_mem_col_ccl_stream_bank;
    localparam int N          = 5;
    localparam int DEPTH      = 4096;
    localparam int AW         = 12;
    localparam int DATA_W     = 5;
    localparam int LEN_W      = 13;
    localparam int SPI_ADDR_W = 12;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          spi_wen;
    logic [SPI_ADDR_W-1:0] spi_addr;
    logic [31:0]           spi_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef logic [31:0] q_t[$];
    q_t                exp_q    [N];
    logic [DATA_W-1:0] model    [N][DEPTH];
    int                exp_done [N];
    int                done_cnt [N];
    int                done_at  [N];
    int                beats    [N];
    bit                stall_prev [N];
    logic [31:0]       held     [N];

    mem_col_ccl_stream_bank_if #(
        .N_PE_COL(N), .AW(AW), .LEN_W(LEN_W), .DATA_W(DATA_W)
    ) bus ();

    mem_col_ccl_stream_bank #(
        .N_PE_COL(N), .DEPTH(DEPTH), .DATA_W(DATA_W), .LEN_W(LEN_W), .SPI_ADDR_W(SPI_ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .spi_wen  (spi_wen),
        .SPI_ADDR (spi_addr),
        .SPI_DATA (spi_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic spi_write(input int ch, input int addr, input int data);
        spi_wen      = '0;
        spi_wen[ch]  = 1'b1;
        spi_addr     = addr[SPI_ADDR_W-1:0];
        spi_data     = data;
        model[ch][addr % DEPTH] = data[DATA_W-1:0];
        step(1);
        spi_wen = '0;
    endtask

    task automatic send_cmd(input int ch, input int addr, input int len, input bit use_model,
                            output int acc);
        int n = 0;
        while (!bus.cmd_rdy[ch] && n < 100) begin
            step(1);
            n++;
        end
        check($sformatf("cmd_rdy%0d", ch), 32'(bus.cmd_rdy[ch]), 1);
        if (use_model) begin
            for (int k = 0; k < len; k++) begin
                exp_q[ch].push_back((int'(k == len - 1) << DATA_W) | int'(model[ch][(addr + k) % DEPTH]));
            end
        end
        exp_done[ch]++;
        bus.cmd_vld[ch]  = 1'b1;
        bus.cmd_addr[ch] = addr[AW-1:0];
        bus.cmd_len[ch]  = len[LEN_W-1:0];
        step(1);
        bus.cmd_vld[ch] = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle(input int ch, input string tag);
        int n = 0;
        while ((exp_q[ch].size() != 0 || !bus.cmd_rdy[ch]) && n < 300) begin
            step(1);
            n++;
        end
        step(2);
        check({tag, "_drained"}, exp_q[ch].size(), 0);
        check({tag, "_done_cnt"}, done_cnt[ch], exp_done[ch]);
    endtask

    // Stream monitor: scoreboard compare on handshake, stability while stalled, done tracking.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < N; ch++) stall_prev[ch] = 1'b0;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                logic [31:0] cur;
                cur = (32'(bus.rd_last[ch]) << DATA_W) | 32'(bus.rd_data[ch]);
                if (bus.rd_vld[ch]) begin
                    if (stall_prev[ch]) check($sformatf("stable%0d", ch), cur, held[ch]);
                    if (bus.rd_rdy[ch]) begin
                        check($sformatf("beat_avail%0d", ch), 32'(exp_q[ch].size() > 0), 1);
                        if (exp_q[ch].size() > 0) check($sformatf("beat%0d", ch), cur, exp_q[ch].pop_front());
                        beats[ch]++;
                    end
                    stall_prev[ch] = !bus.rd_rdy[ch];
                    held[ch]       = cur;
                end else begin
                    if (stall_prev[ch]) check($sformatf("vld_hold%0d", ch), 32'(bus.rd_vld[ch]), 1);
                    stall_prev[ch] = 1'b0;
                end
                if (bus.done[ch]) begin
                    done_cnt[ch]++;
                    done_at[ch] = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d limit=50000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, acc3, b3;
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        for (int ch = 0; ch < N; ch++) begin
            exp_done[ch] = 0;
            done_cnt[ch] = 0;
            done_at[ch]  = 0;
            beats[ch]    = 0;
            held[ch]     = '0;
        end
        spi_wen      = '0;
        spi_addr     = '0;
        spi_data     = '0;
        bus.cmd_vld  = '0;
        bus.cmd_addr = '0;
        bus.cmd_len  = '0;
        bus.rd_rdy   = '0;
        rst_n        = 1'b0;
        step(3);

        check("rst_cmd_rdy", 32'(bus.cmd_rdy), (1 << N) - 1);
        check("rst_rd_vld",  32'(bus.rd_vld), 0);
        check("rst_rd_last", 32'(bus.rd_last), 0);
        check("rst_done",    32'(bus.done), 0);
        check("rst_par_err", 32'(bus.par_err), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        rst_n = 1'b1;
        step(1);

        // Basic burst with latency and done timing.
        for (int k = 0; k < 4; k++) spi_write(0, k, k + 1);
        bus.rd_rdy[0] = 1'b1;
        send_cmd(0, 0, 4, 1'b1, acc);
        check("t1_c1_vld", 32'(bus.rd_vld[0]), 0);
        step(1);
        check("t1_c2_vld", 32'(bus.rd_vld[0]), 1);
        step(2);
        check("t1_c4_last", 32'(bus.rd_last[0]), 0);
        step(1);
        check("t1_c5_last", 32'(bus.rd_last[0]), 1);
        check("t1_c5_vld", 32'(bus.rd_vld[0]), 1);
        step(1);
        check("t1_c6_done", 32'(bus.done[0]), 1);
        check("t1_c6_vld", 32'(bus.rd_vld[0]), 0);
        step(1);
        check("t1_c7_done", 32'(bus.done[0]), 0);
        check("t1_done_cyc", done_at[0] - acc, 5);
        wait_idle(0, "t1");

        // Address wrap on bank 2 concurrently with backpressure on bank 3.
        spi_write(2, 4094, 7);
        spi_write(2, 4095, 8);
        spi_write(2, 0, 9);
        for (int k = 0; k < 4; k++) spi_write(3, 20 + k, 5'h11 + k);
        b3 = beats[3];
        bus.rd_rdy[2] = 1'b1;
        fork
            send_cmd(2, 4094, 3, 1'b1, acc2);
            send_cmd(3, 20, 4, 1'b1, acc3);
        join
        for (int k = 0; k < 7; k++) begin
            bus.rd_rdy[3] = pat[k];
            step(1);
        end
        bus.rd_rdy[3] = 1'b1;
        wait_idle(2, "wrap");
        wait_idle(3, "bp");
        check("bp_beats", beats[3] - b3, 4);

        // SPI writes stall issue on bank 1 for 3 cycles; pending addresses return new data.
        for (int k = 0; k < 6; k++) spi_write(1, 100 + k, k + 1);
        bus.rd_rdy[1] = 1'b1;
        for (int k = 0; k < 4; k++) exp_q[1].push_back(k + 1);
        exp_q[1].push_back(5'h1E);
        exp_q[1].push_back((1 << DATA_W) | 5'h1F);
        send_cmd(1, 100, 6, 1'b0, acc);
        step(2);
        spi_write(1, 104, 5'h1E);
        spi_write(1, 105, 5'h1F);
        spi_write(1, 300, 5'h0A);
        wait_idle(1, "cont");
        check("cont_done_cyc", done_at[1] - acc, 10);

        // Zero-length command.
        send_cmd(4, 0, 0, 1'b1, acc);
        check("len0_cmd_rdy", 32'(bus.cmd_rdy[4]), 1);
        check("len0_done", 32'(bus.done[4]), 1);
        check("len0_vld", 32'(bus.rd_vld[4]), 0);
        step(1);
        check("len0_done_off", 32'(bus.done[4]), 0);
        wait_idle(4, "len0");

        // Reset in the middle of a stalled burst.
        bus.rd_rdy[0] = 1'b0;
        send_cmd(0, 0, 4, 1'b1, acc);
        step(3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(bus.rd_vld[0]), 0);
        check("mid_rst_cmd_rdy", 32'(bus.cmd_rdy[0]), 1);
        exp_q[0].delete();
        exp_done[0]--;
        step(1);
        rst_n = 1'b1;
        bus.rd_rdy[0] = 1'b1;
        step(6);
        check("mid_rst_no_done", done_cnt[0], exp_done[0]);
        check("mid_rst_idle_vld", 32'(bus.rd_vld[0]), 0);
        send_cmd(0, 0, 2, 1'b1, acc);
        wait_idle(0, "post_rst");

`ifdef CCL_PARITY_EN
        spi_write(0, 10, 5'h15);
        dut.g_ch[0].mem[10][DATA_W] = ~dut.g_ch[0].mem[10][DATA_W];
        check("par_pre", 32'(bus.par_err[0]), 0);
        send_cmd(0, 10, 1, 1'b1, acc);
        wait_idle(0, "par_bad");
        check("par_set", 32'(bus.par_err[0]), 1);
        step(3);
        check("par_sticky", 32'(bus.par_err[0]), 1);
        spi_write(0, 11, 5'h03);
        send_cmd(0, 11, 1, 1'b1, acc);
        check("par_clear", 32'(bus.par_err[0]), 0);
        wait_idle(0, "par_ok");
        check("par_clean", 32'(bus.par_err[0]), 0);
`else
        check("par_err_off", 32'(bus.par_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
